// File: rtl/spi_controller.sv
// SPI mode-0 write-frame transmitter for the 16-bit register-write link.
// Sends one {rw, addr, data} frame MSB-first, framed by ncs.
module spi_controller #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int CS_GAP      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    output logic       busy,
    output logic       done
);

    localparam int M1   = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
    localparam int M2   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC);

    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [15:0]   shreg;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // The top of the shift register is the wire; clearing it idles copi low.
    assign copi      = shreg[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            sclk  <= 1'b0;
            ncs   <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        shreg <= {req_rw, req_addr, req_data};
                        ncs   <= 1'b0;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt   <= '0;
                        state <= LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HALF_END) begin
                        cnt  <= '0;
                        sclk <= 1'b0;
                        if (idx == 4'd15) begin
                            state <= HOLD;
                        end else begin
                            // next bit appears together with the falling edge
                            idx   <= idx + 1'b1;
                            shreg <= {shreg[14:0], 1'b0};
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_END) begin
                        cnt   <= '0;
                        ncs   <= 1'b1;
                        shreg <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
